// File: rtl/cmd_reg_bank_hs.sv
// -----------------------------------------------------------------------------
// cmd_reg_bank_hs
//   Bank of CH_NUM CPU-writable command registers at base_addr .. base_addr+CH_NUM-1
//   plus a status register at base_addr+CH_NUM. A CPU write to an idle channel
//   latches the command and raises cmd_vld until the consumer acks, the
//   programmable timeout expires, or the channel is cleared.
//
// Ports
//   clks, reset       clock, synchronous active-high reset
//   cpu_data_in       CPU write data
//   cpu_addr          CPU address (ADDR_WIDTH bits, wraps)
//   cpu_wr, cpu_rd    single-cycle write / read strobes
//   cpu_data_out      registered read data, held until the next read
//   base_addr         address of channel 0
//   tmo_limit         ack timeout in cycles, 0 disables
//   cmd_clr           per-channel clear (highest priority after reset)
//   cmd_vld, cmd_ack  per-channel command handshake
//   dout              command data, channel ch at [ch*VLD_WIDTH +: VLD_WIDTH]
//
// Status register: [ch] pending, [8+ch] done, [16+ch] ovr, [24+ch] tmo.
// done/ovr/tmo are sticky, write-1-to-clear; a same-cycle set beats the clear.
// -----------------------------------------------------------------------------
module cmd_reg_bank_hs #(
    parameter int CH_NUM     = 4,
    parameter int VLD_WIDTH  = 32,
    parameter int ADDR_WIDTH = 20,
    parameter int TMO_WIDTH  = 16
) (
    input  logic                        clks,
    input  logic                        reset,
    input  logic [31:0]                 cpu_data_in,
    input  logic [ADDR_WIDTH-1:0]       cpu_addr,
    input  logic                        cpu_wr,
    input  logic                        cpu_rd,
    output logic [31:0]                 cpu_data_out,
    input  logic [ADDR_WIDTH-1:0]       base_addr,
    input  logic [TMO_WIDTH-1:0]        tmo_limit,
    input  logic [CH_NUM-1:0]           cmd_clr,
    output logic [CH_NUM-1:0]           cmd_vld,
    input  logic [CH_NUM-1:0]           cmd_ack,
    output logic [CH_NUM*VLD_WIDTH-1:0] dout
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    state_t                r_state     [CH_NUM];
    state_t                w_state_nxt [CH_NUM];
    logic [VLD_WIDTH-1:0]  r_dout      [CH_NUM];
    logic [TMO_WIDTH-1:0]  r_cnt       [CH_NUM];
    logic [CH_NUM-1:0]     r_done;
    logic [CH_NUM-1:0]     r_ovr;
    logic [CH_NUM-1:0]     r_tmo;
    logic [31:0]           r_rdata;

    logic [CH_NUM-1:0]     w_wr_hit;
    logic [CH_NUM-1:0]     w_load;
    logic [CH_NUM-1:0]     w_ack_ev;
    logic [CH_NUM-1:0]     w_tmo_ev;
    logic [CH_NUM-1:0]     w_ovr_ev;
    logic [CH_NUM-1:0]     w_pend;
    logic [CH_NUM-1:0]     w_w1c_done;
    logic [CH_NUM-1:0]     w_w1c_ovr;
    logic [CH_NUM-1:0]     w_w1c_tmo;
    logic [ADDR_WIDTH-1:0] w_stat_addr;
    logic                  w_wr_stat;
    logic [TMO_WIDTH-1:0]  w_tmo_last;
    logic [31:0]           w_status;
    logic [31:0]           w_rd_val;

    // Address sums are truncated to ADDR_WIDTH, so the bank may wrap past the top of the map.
    assign w_stat_addr = base_addr + ADDR_WIDTH'(CH_NUM);
    assign w_wr_stat   = cpu_wr && (cpu_addr == w_stat_addr);
    // Counter starts at 0 in the first valid cycle, so matching limit-1 gives exactly limit cycles.
    assign w_tmo_last  = tmo_limit - TMO_WIDTH'(1);

    assign w_w1c_done  = w_wr_stat ? cpu_data_in[8  +: CH_NUM] : '0;
    assign w_w1c_ovr   = w_wr_stat ? cpu_data_in[16 +: CH_NUM] : '0;
    assign w_w1c_tmo   = w_wr_stat ? cpu_data_in[24 +: CH_NUM] : '0;

    // Per-channel next-state and event decode
    always_comb begin
        for (int ch = 0; ch < CH_NUM; ch++) begin
            w_state_nxt[ch] = r_state[ch];
            w_load[ch]      = 1'b0;
            w_ack_ev[ch]    = 1'b0;
            w_tmo_ev[ch]    = 1'b0;
            w_ovr_ev[ch]    = 1'b0;
            w_pend[ch]      = (r_state[ch] == ST_PEND);
            w_wr_hit[ch]    = cpu_wr && (cpu_addr == base_addr + ADDR_WIDTH'(ch));
            if (cmd_clr[ch]) begin
                // Clear swallows any same-cycle write without flagging an overrun.
                w_state_nxt[ch] = ST_IDLE;
            end else begin
                case (r_state[ch])
                    ST_IDLE: begin
                        if (w_wr_hit[ch]) begin
                            w_load[ch]      = 1'b1;
                            w_state_nxt[ch] = ST_PEND;
                        end
                    end
                    ST_PEND: begin
                        w_ovr_ev[ch] = w_wr_hit[ch];
                        if (cmd_ack[ch]) begin
                            w_ack_ev[ch]    = 1'b1;
                            w_state_nxt[ch] = ST_IDLE;
                        end else if ((tmo_limit != '0) && (r_cnt[ch] == w_tmo_last)) begin
                            w_tmo_ev[ch]    = 1'b1;
                            w_state_nxt[ch] = ST_IDLE;
                        end
                    end
                    default: w_state_nxt[ch] = ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clks) begin
        for (int ch = 0; ch < CH_NUM; ch++) begin
            if (reset) begin
                r_state[ch] <= ST_IDLE;
            end else begin
                r_state[ch] <= w_state_nxt[ch];
            end
        end
    end

    // Command data and timeout counters
    always_ff @(posedge clks) begin
        for (int ch = 0; ch < CH_NUM; ch++) begin
            if (reset || cmd_clr[ch]) begin
                r_dout[ch] <= '0;
                r_cnt[ch]  <= '0;
            end else if (w_load[ch]) begin
                r_dout[ch] <= cpu_data_in[VLD_WIDTH-1:0];
                r_cnt[ch]  <= '0;
            end else if (w_pend[ch] && (r_cnt[ch] != '1)) begin
                r_cnt[ch]  <= r_cnt[ch] + TMO_WIDTH'(1);
            end
        end
    end

    // Sticky status bits: clear first, then OR in new events so a set always wins.
    always_ff @(posedge clks) begin
        if (reset) begin
            r_done <= '0;
            r_ovr  <= '0;
            r_tmo  <= '0;
        end else begin
            r_done <= (r_done & ~w_w1c_done) | w_ack_ev;
            r_ovr  <= (r_ovr  & ~w_w1c_ovr)  | w_ovr_ev;
            r_tmo  <= (r_tmo  & ~w_w1c_tmo)  | w_tmo_ev;
        end
    end

    always_comb begin
        w_status                = '0;
        w_status[0  +: CH_NUM]  = w_pend;
        w_status[8  +: CH_NUM]  = r_done;
        w_status[16 +: CH_NUM]  = r_ovr;
        w_status[24 +: CH_NUM]  = r_tmo;
    end

    // Read mux uses pre-edge state, so a same-cycle write is not visible to the read.
    always_comb begin
        w_rd_val = '0;
        if (cpu_addr == w_stat_addr) begin
            w_rd_val = w_status;
        end else begin
            for (int ch = 0; ch < CH_NUM; ch++) begin
                if (cpu_addr == base_addr + ADDR_WIDTH'(ch)) begin
                    w_rd_val[VLD_WIDTH-1:0] = r_dout[ch];
                end
            end
        end
    end

    always_ff @(posedge clks) begin
        if (reset) begin
            r_rdata <= '0;
        end else if (cpu_rd) begin
            r_rdata <= w_rd_val;
        end
    end

    assign cmd_vld      = w_pend;
    assign cpu_data_out = r_rdata;

    always_comb begin
        dout = '0;
        for (int ch = 0; ch < CH_NUM; ch++) begin
            dout[ch*VLD_WIDTH +: VLD_WIDTH] = r_dout[ch];
        end
    end

endmodule
